// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result display: FSM encoding,
// seven-segment patterns (active-low {g,f,e,d,c,b,a}) and digit indices.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [1:0] DIG_ONES     = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;
    localparam logic [1:0] DIG_SIGN     = 2'd3;

    // Add-3 correction applied to every nibble of the BCD scratch before a shift.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        if (r[3:0]  >= 4'd5) r[3:0]  = r[3:0]  + 4'd3;
        if (r[7:4]  >= 4'd5) r[7:4]  = r[7:4]  + 4'd3;
        if (r[11:8] >= 4'd5) r[11:8] = r[11:8] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] digit_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_DIGIT[0];
            4'd1:    s = SEG_DIGIT[1];
            4'd2:    s = SEG_DIGIT[2];
            4'd3:    s = SEG_DIGIT[3];
            4'd4:    s = SEG_DIGIT[4];
            4'd5:    s = SEG_DIGIT[5];
            4'd6:    s = SEG_DIGIT[6];
            4'd7:    s = SEG_DIGIT[7];
            4'd8:    s = SEG_DIGIT[8];
            4'd9:    s = SEG_DIGIT[9];
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3, one bit per clock).
// The sign flag rides along so it lands on the display together with the magnitude.
//
//  state    | meaning
//  ST_IDLE  | waiting for i_Load; clears o_Busy/o_Done after a conversion
//  ST_SHIFT | eight adjust-and-shift steps, shift_cnt counts down 7..0
//  ST_DONE  | publish scratch to o_BCD/o_Neg, pulse o_Done
module bin_to_bcd_seq
    import calc_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Load,
    input  logic [7:0]  i_Bin,
    input  logic        i_Neg,
    output logic        o_Busy,
    output logic        o_Done,
    output logic [11:0] o_BCD,
    output logic        o_Neg
);

    conv_state_t state;
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [2:0]  shift_cnt;
    logic        neg_pend;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= ST_IDLE;
            bin       <= '0;
            bcd       <= '0;
            shift_cnt <= '0;
            neg_pend  <= 1'b0;
            o_Busy    <= 1'b0;
            o_Done    <= 1'b0;
            o_BCD     <= '0;
            o_Neg     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_Busy <= 1'b0;
                    o_Done <= 1'b0;
                    // o_Busy is still high in the cycle after DONE, so a load there is dropped
                    if (i_Load && !o_Busy) begin
                        bin       <= i_Bin;
                        neg_pend  <= i_Neg;
                        bcd       <= '0;
                        shift_cnt <= 3'd7;
                        o_Busy    <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd, bin} <= {bcd_adjust(bcd), bin} << 1;
                    shift_cnt  <= shift_cnt - 3'd1;
                    if (shift_cnt == 3'd0) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_BCD  <= bcd;
                    o_Neg  <= neg_pend;
                    o_Done <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/calc_result_display.sv
// Calculator result consumer: converts the magnitude to BCD and scans sign/hundreds/
// tens/ones onto a 4-digit multiplexed active-low seven-segment display.
module calc_result_display
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Load,
    input  logic [7:0]  i_Result,
    input  logic        i_Neg,
    output logic        o_Busy,
    output logic        o_Done,
    output logic [11:0] o_BCD,
    output logic [6:0]  o_Seg,
    output logic [3:0]  o_An
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic             disp_neg;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       dig_idx;
    logic             scan_tc;
    logic [1:0]       dig_next;
    logic [6:0]       seg_next;
    logic [3:0]       hund;
    logic [3:0]       tens;
    logic [3:0]       ones;

    bin_to_bcd_seq u_conv (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Load  (i_Load),
        .i_Bin   (i_Result),
        .i_Neg   (i_Neg),
        .o_Busy  (o_Busy),
        .o_Done  (o_Done),
        .o_BCD   (o_BCD),
        .o_Neg   (disp_neg)
    );

    assign hund = o_BCD[11:8];
    assign tens = o_BCD[7:4];
    assign ones = o_BCD[3:0];

    always_comb begin
        scan_tc  = (scan_cnt == CNT_W'(REFRESH_DIV - 1));
        dig_next = scan_tc ? dig_idx + 2'd1 : dig_idx;
        seg_next = SEG_BLANK;
        // Leading zeros are blanked; ones is always lit so zero reads "0"
        case (dig_next)
            DIG_ONES:     seg_next = digit_seg(ones);
            DIG_TENS:     seg_next = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : digit_seg(tens);
            DIG_HUNDREDS: seg_next = (hund == 4'd0) ? SEG_BLANK : digit_seg(hund);
            DIG_SIGN:     seg_next = (disp_neg && o_BCD != 12'd0) ? SEG_MINUS : SEG_BLANK;
            default:      seg_next = SEG_BLANK;
        endcase
    end

    // Segment and anode registers follow the index that is about to be current,
    // so they switch on the same edge as dig_idx.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            scan_cnt <= '0;
            dig_idx  <= DIG_ONES;
            o_Seg    <= SEG_DIGIT[0];
            o_An     <= 4'b1110;
        end else begin
            scan_cnt <= scan_tc ? '0 : scan_cnt + CNT_W'(1);
            dig_idx  <= dig_next;
            o_Seg    <= seg_next;
            o_An     <= ~(4'b0001 << dig_next);
        end
    end

endmodule
